// File: rtl/tristate_bus_arbiter.sv
// tristate_bus_arbiter: round-robin owner selection for a shared tristate bus.
// Drives the per-requester buffer enables directly. At most one enable is ever
// high, and every change of owner passes through at least one all-off cycle.
// Optional feature macro: BUS_TIMEOUT_EN adds the hold counter and revokes an
// owner after HOLD_MAX grant cycles. Without it the counter is removed and
// timeout_o is tied low.
module tristate_bus_arbiter #(
  parameter int NREQ     = 4,
  parameter int HOLD_MAX = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NREQ-1:0]          req_i,
  output logic [NREQ-1:0]          grant_o,
  output logic [$clog2(NREQ)-1:0]  grant_id_o,
  output logic                     bus_busy_o,
  output logic                     timeout_o
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } state_e;

  // Parameter range check at elaboration; HOLD_MAX is ignored by the logic
  // when the timeout feature is compiled out.
  if (NREQ < 2 || NREQ > 8) begin : gBadNreq
    $error("tristate_bus_arbiter: NREQ must be in 2..8");
  end
  if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : gBadHold
    $error("tristate_bus_arbiter: HOLD_MAX must be in 2..255");
  end

  state_e           state_q, state_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [IDW-1:0]   grant_id_q, grant_id_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   winner;
  logic [IDW-1:0]   nextPtr;

`ifdef BUS_TIMEOUT_EN
  localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);
  logic [7:0]       cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
`endif

  // Round-robin scan: first set request at or after ptr_q, with wrap-around.
  always_comb begin
    int             idx;
    logic [IDW-1:0] idxN;
    logic           found;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    idxN   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx  = (int'(ptr_q) + i) % NREQ;
      idxN = IDW'(idx);
      if (!found && req_i[idxN]) begin
        found  = 1'b1;
        winner = idxN;
      end
    end
    nextPtr = (winner == IDW'(NREQ - 1)) ? '0 : winner + IDW'(1);
  end

  // Next-state logic: IDLE picks a winner, OWN waits for release (or revokes
  // on timeout), GAP keeps all enables off for one turnaround cycle.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    ptr_d      = ptr_q;
`ifdef BUS_TIMEOUT_EN
    cnt_d      = cnt_q;
    timeout_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (|req_i) begin
          state_d    = OWN;
          grant_d    = NREQ'(1) << winner;
          grant_id_d = winner;
          ptr_d      = nextPtr;
`ifdef BUS_TIMEOUT_EN
          cnt_d      = 8'd1;
`endif
        end
      end
      OWN: begin
        if (!req_i[grant_id_q]) begin
          state_d    = GAP;
          grant_d    = '0;
          grant_id_d = '0;
        end
`ifdef BUS_TIMEOUT_EN
        else if (cnt_q >= HOLD_LIM) begin
          state_d    = GAP;
          grant_d    = '0;
          grant_id_d = '0;
          timeout_d  = 1'b1;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d    = IDLE;
        grant_d    = '0;
        grant_id_d = '0;
      end
    endcase
  end

  // State and output registers; reset drops every enable immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      ptr_q      <= '0;
`ifdef BUS_TIMEOUT_EN
      cnt_q      <= 8'd0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      ptr_q      <= ptr_d;
`ifdef BUS_TIMEOUT_EN
      cnt_q      <= cnt_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  assign grant_o    = grant_q;
  assign grant_id_o = grant_id_q;
  assign bus_busy_o = |grant_q;
`ifdef BUS_TIMEOUT_EN
  assign timeout_o  = timeout_q;
`else
  assign timeout_o  = 1'b0;
`endif

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// tb_tristate_bus_arbiter: directed checks of the tristate bus arbiter with
// NREQ=4, HOLD_MAX=8. The timeout scenario follows BUS_TIMEOUT_EN.
module tb_tristate_bus_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] grantId;
  logic       busBusy;
  logic       timeoutPulse;

  int testsRun    = 0;
  int testsFailed = 0;
  logic [3:0] prevGrant = 4'b0000;

  tristate_bus_arbiter #(
    .NREQ    (4),
    .HOLD_MAX(8)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .req_i     (req),
    .grant_o   (grant),
    .grant_id_o(grantId),
    .bus_busy_o(busBusy),
    .timeout_o (timeoutPulse)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive the request vector, then advance one clock and settle past the edge.
  task automatic applyStimulus(input logic [3:0] reqValue);
    req = reqValue;
    @(posedge clk);
    #1;
  endtask

  // Compare every output against its expected value.
  task automatic checkOutput(input string tag, input logic [3:0] expGrant,
                             input logic [1:0] expId, input logic expTimeout);
    logic expBusy;
    expBusy = |expGrant;
    testsRun++;
    assert ({grant, grantId, busBusy, timeoutPulse} ===
            {expGrant, expId, expBusy, expTimeout})
    else begin
      testsFailed++;
      $error("[TB] FAIL %s: got grant=%b id=%0d busy=%b timeout=%b, required grant=%b id=%0d busy=%b timeout=%b",
             tag, grant, grantId, busBusy, timeoutPulse, expGrant, expId, expBusy, expTimeout);
    end
  endtask

  // Contention monitor: grant one-hot or zero, owner changes only via zero.
  always @(negedge clk) begin
    testsRun++;
    assert ($onehot0(grant))
    else begin
      testsFailed++;
      $error("[TB] FAIL onehot: got grant=%b, required one-hot or zero", grant);
    end
    if (prevGrant != 4'b0000 && grant != 4'b0000) begin
      testsRun++;
      assert (grant === prevGrant)
      else begin
        testsFailed++;
        $error("[TB] FAIL gap: got grant=%b after %b, required an all-zero cycle between owners",
               grant, prevGrant);
      end
    end
    prevGrant = grant;
  end

  // Directed scenario sequence.
  initial begin
    int ownerSeq[5] = '{0, 1, 2, 3, 0};
    rst = 1'b1;
    req = 4'b0000;
    applyStimulus(4'b0000);
    applyStimulus(4'b0000);
    checkOutput("reset", 4'b0000, 2'd0, 1'b0);

    // Reset asserted mid-ownership, then a fresh request.
    rst = 1'b0;
    applyStimulus(4'b0010);
    checkOutput("grant1", 4'b0010, 2'd1, 1'b0);
    applyStimulus(4'b0010);
    checkOutput("hold1", 4'b0010, 2'd1, 1'b0);
    #2 rst = 1'b1;
    #1 checkOutput("asyncReset", 4'b0000, 2'd0, 1'b0);
    applyStimulus(4'b0001);
    checkOutput("inReset", 4'b0000, 2'd0, 1'b0);
    rst = 1'b0;
    applyStimulus(4'b0001);
    checkOutput("grant0AfterReset", 4'b0001, 2'd0, 1'b0);
    applyStimulus(4'b0000);
    checkOutput("gapAfterRelease", 4'b0000, 2'd0, 1'b0);
    applyStimulus(4'b0000);
    checkOutput("idleAfterGap", 4'b0000, 2'd0, 1'b0);

    // Round-robin with all requesters active; pointer cleared by reset.
    rst = 1'b1;
    applyStimulus(4'b0000);
    rst = 1'b0;
    for (int n = 0; n < 5; n++) begin
      logic [3:0] ownerBit;
      ownerBit = 4'b0001 << ownerSeq[n];
      for (int c = 0; c < 3; c++) begin
        applyStimulus(4'b1111);
        checkOutput("rrOwn", ownerBit, 2'(ownerSeq[n]), 1'b0);
      end
      applyStimulus(4'b1111 & ~ownerBit);
      checkOutput("rrGap", 4'b0000, 2'd0, 1'b0);
      applyStimulus(4'b1111);
      checkOutput("rrIdle", 4'b0000, 2'd0, 1'b0);
    end
    applyStimulus(4'b0000);
    checkOutput("rrDone", 4'b0000, 2'd0, 1'b0);

    // Wrap-around: pointer at 1, grant 2 moves it to 3, then 0 wins.
    applyStimulus(4'b0100);
    checkOutput("wrapGrant2", 4'b0100, 2'd2, 1'b0);
    applyStimulus(4'b0011);
    checkOutput("wrapGap", 4'b0000, 2'd0, 1'b0);
    applyStimulus(4'b0011);
    checkOutput("wrapIdle", 4'b0000, 2'd0, 1'b0);
    applyStimulus(4'b0011);
    checkOutput("wrapGrant0", 4'b0001, 2'd0, 1'b0);
    applyStimulus(4'b1010);
    checkOutput("wrapGap2", 4'b0000, 2'd0, 1'b0);
    applyStimulus(4'b1010);
    checkOutput("wrapIdle2", 4'b0000, 2'd0, 1'b0);
    applyStimulus(4'b1010);
    checkOutput("ptrIsOne", 4'b0010, 2'd1, 1'b0);
    applyStimulus(4'b0000);
    checkOutput("ptrGap", 4'b0000, 2'd0, 1'b0);
    applyStimulus(4'b0000);

    // Long hold by requester 1 while requester 2 waits.
    rst = 1'b1;
    applyStimulus(4'b0000);
    rst = 1'b0;
    applyStimulus(4'b0110);
    checkOutput("holdCycle1", 4'b0010, 2'd1, 1'b0);
    for (int c = 2; c <= 8; c++) begin
      applyStimulus(4'b0110);
      checkOutput("holdCycle", 4'b0010, 2'd1, 1'b0);
    end
`ifdef BUS_TIMEOUT_EN
    applyStimulus(4'b0110);
    checkOutput("timeoutPulse", 4'b0000, 2'd0, 1'b1);
    applyStimulus(4'b0110);
    checkOutput("timeoutIdle", 4'b0000, 2'd0, 1'b0);
    applyStimulus(4'b0110);
    checkOutput("timeoutNextOwner", 4'b0100, 2'd2, 1'b0);
    for (int c = 2; c <= 8; c++) begin
      applyStimulus(4'b0110);
      checkOutput("tieHold", 4'b0100, 2'd2, 1'b0);
    end
    applyStimulus(4'b0010);
    checkOutput("tieNoPulse", 4'b0000, 2'd0, 1'b0);
    applyStimulus(4'b0000);
    checkOutput("tieIdle", 4'b0000, 2'd0, 1'b0);
`else
    for (int c = 9; c <= 20; c++) begin
      applyStimulus(4'b0110);
      checkOutput("noTimeoutHold", 4'b0010, 2'd1, 1'b0);
    end
    applyStimulus(4'b0000);
    checkOutput("noTimeoutGap", 4'b0000, 2'd0, 1'b0);
    applyStimulus(4'b0000);
    checkOutput("noTimeoutIdle", 4'b0000, 2'd0, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/tristate_bus_arbiter.md
# tristate_bus_arbiter

Round-robin arbiter that shares the SoC's single tristate data bus among `NREQ` requesters. It sequences the per-requester `active_high_buffer` enables, and at most one enable is ever high. A mandatory one-cycle all-off gap between owners prevents drive contention. An optional hold timeout revokes a requester that holds the bus too long. It sits between the bus masters (core, DMA, debug) and their output buffers.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `HOLD_MAX`, 8: maximum consecutive grant cycles per ownership, 2..255. Used only with the timeout feature.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `req` input NREQ: per-requester bus request, level; sampled on `clk`.
- `grant` output NREQ: one-hot or zero. Drives the buffer `enable` pins directly. Registered.
- `grant_id` output $clog2(NREQ): index of current owner. Valid only while `bus_busy`; otherwise 0.
- `bus_busy` output 1: high while any `grant` bit is high.
- `timeout` output 1: one-cycle pulse when an ownership is revoked by timeout.

## Operation
- FSM states, 2-bit encoding:
  - IDLE: no owner.
  - OWN: `grant` high for the owner.
  - GAP: all enables off for one turnaround cycle.
- IDLE:
  - If `req` != 0, select a winner by round-robin starting at pointer `ptr`, then go to OWN.
  - Otherwise stay in IDLE.
- OWN:
  - If `req[grant_id]` == 0, go to GAP.
  - With timeout enabled, if the hold counter has reached `HOLD_MAX` and `req[grant_id]` is still 1, go to GAP and pulse `timeout`.
  - Otherwise stay in OWN.
- GAP: always go to IDLE. Requests arriving during GAP wait for IDLE.
- Round-robin:
  - `ptr` resets to 0.
  - On a grant to index k, `ptr` = (k+1) mod NREQ.
  - Winner is the first set `req` bit scanning k = ptr, ptr+1, … with wrap-around.
- Hold counter:
  - 8 bits; loads 1 on entry to OWN and increments each OWN cycle.
  - Saturates at 255 and does not wrap.
- A revoked requester is not blacklisted. It wins again only if no other requester is pending when its turn in the pointer order comes.
- `req` bits of non-owners changing during OWN have no effect until the next IDLE.
- Simultaneous release and timeout on the same cycle count as a release: no `timeout` pulse.
- `rst` asserted mid-operation:
  - All outputs go low immediately (asynchronous).
  - State goes to IDLE; `ptr` and the counter clear.
- Invariant: `grant` is never multi-hot. It is zero in IDLE and GAP and on reset.

## Timing
- Reset values:
  - `grant` = 0, `grant_id` = 0, `bus_busy` = 0, `timeout` = 0.
  - State = IDLE, `ptr` = 0, counter = 0.
- Request to grant: `req` high at edge N in IDLE gives `grant` high after edge N, so latency is 1 cycle.
- Release: `req[owner]` low at edge N gives `grant` low after edge N.
- Handoff: minimum one GAP cycle plus one IDLE cycle with all enables low between two owners. Back-to-back handoff is 2 dead cycles.
- Timeout: the owner holds exactly `HOLD_MAX` grant cycles. `timeout` is high in the first GAP cycle.
- `bus_busy` and `grant_id` change on the same edges as `grant`.

## Configuration
- `BUS_TIMEOUT_EN` defined:
  - The hold counter, the revoke path and the `timeout` output logic are compiled in.
- `BUS_TIMEOUT_EN` undefined:
  - The counter is removed; ownership lasts until release.
  - `timeout` is tied to 0, and `HOLD_MAX` is ignored.
  - Port list is unchanged.

## Test plan
- Reset/idle: assert `rst` mid-OWN with `grant`=4'b0010 -> `grant`=0, `bus_busy`=0 asynchronously; after release, `req`=4'b0001 -> `grant`=4'b0001 one cycle later.
- Round-robin: `req`=4'b1111 held, each owner drops `req` after 3 cycles then re-raises -> grant order 0,1,2,3,0, with 2 dead cycles between owners.
- Wrap/priority: `ptr`=3 (after granting 2), `req`=4'b0011 -> `grant_id`=0, then `ptr`=1.
- Timeout (`BUS_TIMEOUT_EN`, `HOLD_MAX`=8): requester 1 holds `req` forever while `req[2]`=1 -> `grant[1]` high exactly 8 cycles, then a `timeout` pulse, then `grant`=4'b0100 two cycles later.
- Timeout tie: owner drops `req` on its 8th cycle -> no `timeout` pulse.
- No-timeout build: same stimulus as the timeout case without the macro -> `grant[1]` stays high indefinitely and `timeout` stays 0.
- Contention monitor (all tests): assert `grant` is one-hot or zero every cycle, and assert no owner change occurs without at least one all-zero cycle.
